// File: rtl/cam_pixel_packer.sv
// Capture-path packer: drains the 10-bit capture FIFO, pairs bytes into RGB565
// pixels and writes them with linear addresses into the frame buffer.
module cam_pixel_packer #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              sof,
  input  logic              fifo_empty,
  input  logic [9:0]        fifo_data,
  output logic              fifo_rd,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [15:0]       pix_data,
  output logic              frame_done,
  output logic              busy,
  output logic              sync_err,
  output logic [1:0]        state_dbg
);

  localparam int X_W   = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int Y_W   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int BYTES = 2 * H_PIX * V_LINES;
  localparam int CNT_W = $clog2(BYTES + 1);

  localparam logic [X_W-1:0]   X_LAST    = X_W'(H_PIX - 1);
  localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_LINES - 1);
  localparam logic [CNT_W-1:0] BYTES_CNT = CNT_W'(BYTES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               phase_q;
  logic [7:0]         hi_q;
  logic               rd_valid_q;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;

  logic run_live, word_ok, word_bad, emit, last_pix, last_byte_read;
  logic unused_vsyn;

  // Handshake: fifo_rd is a request strobe; the FIFO presents the word one
  // cycle later, tracked by rd_valid_q. Only words requested while running
  // are ever turned into pixels; everything else is drained and dropped.
  assign unused_vsyn    = fifo_data[0];
  assign run_live       = (state_q == S_RUN) && capture;
  assign word_ok        = run_live && rd_valid_q && fifo_data[1];
  assign word_bad       = run_live && rd_valid_q && !fifo_data[1];
  assign emit           = word_ok && phase_q;
  assign last_pix       = (x_q == X_LAST) && (y_q == Y_LAST);
  assign last_byte_read = (rd_cnt_q == BYTES_CNT);
  assign busy           = (state_q == S_WAIT_SOF) || (state_q == S_RUN);
  assign state_dbg      = state_q;

  // Dropped Href-low words give their request slot back, so a frame with
  // glitches still fetches enough good bytes to complete.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (fifo_rd && !word_bad) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    else if (!fifo_rd && word_bad) rd_cnt_d = rd_cnt_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    fifo_rd = 1'b0;
    case (state_q)
      S_IDLE: begin
        fifo_rd = !fifo_empty;
        if (capture) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        fifo_rd = !fifo_empty;
        if (!capture) state_d = S_IDLE;
        else if (sof) state_d = S_RUN;
      end
      S_RUN: begin
        fifo_rd = !fifo_empty && !last_byte_read;
        if (!capture) state_d = S_IDLE;
        else if (!sof && emit && last_pix) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = capture ? S_WAIT_SOF : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst) fifo_rd = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_cnt_q   <= '0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_we     <= 1'b0;
      frame_done <= (state_q == S_DONE);
      rd_valid_q <= fifo_rd && run_live;

      if ((state_q == S_WAIT_SOF) && capture && sof) begin
        x_q      <= '0;
        y_q      <= '0;
        addr_q   <= '0;
        phase_q  <= 1'b0;
        rd_cnt_q <= '0;
        sync_err <= 1'b0;
      end

      if (run_live) begin
        rd_cnt_q <= rd_cnt_d;
        if (word_bad) sync_err <= 1'b1;
        if (word_ok) begin
          if (!phase_q) begin
            hi_q    <= fifo_data[9:2];
            phase_q <= 1'b1;
          end else begin
            pix_we   <= 1'b1;
            pix_addr <= addr_q;
            pix_data <= {hi_q, fifo_data[9:2]};
            addr_q   <= addr_q + ADDR_W'(1);
            phase_q  <= 1'b0;
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            end else begin
              x_q <= x_q + X_W'(1);
            end
          end
        end
        // Short frame: restart geometry, but a pixel completing this cycle
        // has already been written above at its old address.
        if (sof) begin
          sync_err <= 1'b1;
          x_q      <= '0;
          y_q      <= '0;
          addr_q   <= '0;
          phase_q  <= 1'b0;
          rd_cnt_q <= {{(CNT_W-1){1'b0}}, fifo_rd};
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Randomised bench for cam_pixel_packer on a reduced frame geometry, with a
// FIFO model, a queue-based pixel reference model and a write scoreboard.
module tb_cam_pixel_packer;

  localparam int H     = 20;
  localparam int V     = 12;
  localparam int AW    = 8;
  localparam int NPIX  = H * V;
  localparam int NBYTE = 2 * NPIX;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          capture = 1'b0;
  logic          sof = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [9:0]    fifo_data = '0;
  logic          fifo_rd, pix_we, frame_done, busy, sync_err;
  logic [AW-1:0] pix_addr;
  logic [15:0]   pix_data;
  logic [1:0]    state_dbg;

  cam_pixel_packer #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .capture(capture), .sof(sof),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_done(frame_done), .busy(busy), .sync_err(sync_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0, we_cnt = 0, done_cnt = 0, last_we_cyc = -10;

  logic [9:0]     fifo_q[$];
  logic [9:0]     stim_q[$];
  logic [9:0]     saved_q[$];
  logic [AW+15:0] exp_q[$];
  logic           gap_mode = 1'b0, gap_phase = 1'b0, rd_seen = 1'b0;

  // ---------------- FIFO model: word appears the cycle after a read strobe
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rd_seen && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    gap_phase  = ~gap_phase;
    fifo_empty = (fifo_q.size() == 0) || (gap_mode && gap_phase);
    @(negedge clk);
    #2;
    rd_seen = fifo_rd;
  end

  // ---------------- scoreboard / monitor
  always @(negedge clk) begin
    logic [AW+15:0] exp_e;
    if (fifo_empty) begin
      vectors++;
      assert (fifo_rd === 1'b0) else begin
        errors++;
        $error("FAIL rd_while_empty: fifo_rd=%b expected 0 (cycle %0d)", fifo_rd, cyc);
      end
    end
    if (pix_we === 1'b1) begin
      we_cnt++;
      last_we_cyc = cyc;
      vectors++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL pix_extra: addr=%0d data=%h expected no write", pix_addr, pix_data);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        assert ({pix_addr, pix_data} === exp_e) else begin
          errors++;
          $error("FAIL pix_write: addr=%0d data=%h expected addr=%0d data=%h",
                 pix_addr, pix_data, exp_e[AW+15:16], exp_e[15:0]);
        end
      end
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      vectors++;
      assert (cyc == last_we_cyc + 1) else begin
        errors++;
        $error("FAIL done_timing: frame_done at cycle %0d expected %0d", cyc, last_we_cyc + 1);
      end
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_sof();
    tick();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic gen_frame(input int nwords, input int bad_idx, input bit incr);
    stim_q.delete();
    for (int i = 0; i < nwords; i++) begin
      logic [7:0] b;
      b = incr ? 8'(i) : 8'($urandom_range(0, 255));
      stim_q.push_back({b, (i != bad_idx), 1'($urandom_range(0, 1))});
    end
  endtask

  // Reference model: only Href-high bytes count; consecutive pairs form
  // pixels numbered from 0 within the frame.
  task automatic push_words(input int npix);
    logic [7:0] good[$];
    foreach (stim_q[i]) begin
      fifo_q.push_back(stim_q[i]);
      if (stim_q[i][1]) good.push_back(stim_q[i][9:2]);
    end
    for (int p = 0; p < npix; p++)
      exp_q.push_back({AW'(p), good[2*p], good[2*p+1]});
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 4000) begin tick(); n++; end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_we(input int target, input string tag);
    int n = 0;
    while (we_cnt < target && n < 4000) begin tick(); n++; end
    check(tag, we_cnt, target);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin tick(); n++; end
    check(tag, fifo_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence
  initial begin
    int base;
    for (int i = 0; i < 3; i++) fifo_q.push_back(10'($urandom_range(0, 1023)));
    repeat (3) tick();
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_pix_we", pix_we, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b1;
    repeat (6) tick();
    check("idle_drained", fifo_q.size(), 0);
    check("idle_no_write", we_cnt, 0);

    // Full frame, full rate, incrementing bytes
    capture = 1'b1;
    repeat (2) tick();
    check("wait_busy", busy, 1);
    check("wait_state", state_dbg, 1);
    pulse_sof();
    check("run_state", state_dbg, 2);
    gen_frame(NBYTE, -1, 1'b1);
    saved_q = stim_q;
    push_words(NPIX);
    wait_done(1, "frame1_done");
    check("frame1_pixels", we_cnt, NPIX);
    check("frame1_sync_err", sync_err, 0);
    tick();
    check("frame1_to_wait", state_dbg, 1);

    // Same stream with FIFO empty every other cycle
    gap_mode = 1'b1;
    pulse_sof();
    stim_q = saved_q;
    push_words(NPIX);
    wait_done(2, "gap_done");
    gap_mode = 1'b0;
    check("gap_pixels", we_cnt, 2 * NPIX);
    check("gap_sync_err", sync_err, 0);

    // Href-low word at byte 5
    pulse_sof();
    gen_frame(NBYTE + 1, 5, 1'b0);
    push_words(NPIX);
    wait_done(3, "href_done");
    check("href_sync_err", sync_err, 1);
    tick();
    check("href_sticky", sync_err, 1);

    // Short frame: second sof after 50 pixels
    pulse_sof();
    check("sof_clears_err", sync_err, 0);
    gen_frame(100, -1, 1'b0);
    push_words(50);
    wait_drain("short_drain");
    repeat (3) tick();
    pulse_sof();
    check("short_sync_err", sync_err, 1);
    check("short_state", state_dbg, 2);
    gen_frame(NBYTE, -1, 1'b0);
    push_words(NPIX);
    wait_done(4, "short_done");
    check("short_err_sticky", sync_err, 1);

    // Capture dropped after 100 pixels
    pulse_sof();
    base = we_cnt;
    gen_frame(NBYTE, -1, 1'b0);
    push_words(100);
    wait_we(base + 100, "drop_reach");
    capture = 1'b0;
    tick();
    check("drop_state", state_dbg, 0);
    check("drop_busy", busy, 0);
    wait_drain("drop_drain");
    repeat (4) tick();
    check("drop_no_more_we", we_cnt, base + 100);
    check("drop_no_done", done_cnt, 4);

    // Continuous mode: two frames back to back
    capture = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      pulse_sof();
      gen_frame(NBYTE, -1, 1'b0);
      push_words(NPIX);
      wait_done(5 + f, "cont_done");
    end
    check("cont_sync_err", sync_err, 0);

    // Reset mid-frame
    pulse_sof();
    base = we_cnt;
    gen_frame(NBYTE, -1, 1'b0);
    push_words(30);
    wait_we(base + 30, "rstmid_reach");
    rst = 1'b0;
    tick();
    check("rstmid_pix_we", pix_we, 0);
    check("rstmid_pix_addr", pix_addr, 0);
    check("rstmid_pix_data", pix_data, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_fifo_rd", fifo_rd, 0);
    check("rstmid_state", state_dbg, 0);
    capture = 1'b0;
    rst = 1'b1;
    wait_drain("rstmid_drain");
    repeat (4) tick();
    check("rstmid_no_more_we", we_cnt, base + 30);
    check("rstmid_no_done", done_cnt, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cam_pixel_packer.md
# cam_pixel_packer

Downstream stage of the camera capture path: drains the 10-bit capture FIFO, pairs consecutive bytes into 16-bit RGB565 pixels, and writes them with linear addresses into the frame-buffer RAM. Owns frame framing: starts on a start-of-frame pulse, counts pixels/lines, flags sync errors and signals frame completion to the Wishbone camera register block.

## Interface
- H_PIX, 160, pixels per line
- V_LINES, 120, lines per frame
- ADDR_W, 15, pixel address width (must satisfy 2^ADDR_W >= H_PIX*V_LINES)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- capture  in  1  capture enable from register block
- sof  in  1  start-of-frame pulse, one clk cycle, already synchronised to clk
- fifo_empty  in  1  capture FIFO empty
- fifo_data  in  10  FIFO word: [9:2] pixel byte, [1] Href, [0] Vsyn; valid the cycle after fifo_rd
- fifo_rd  out  1  FIFO read strobe, one word per asserted cycle
- pix_we  out  1  frame-buffer write strobe, one cycle per pixel
- pix_addr  out  ADDR_W  pixel address, y*H_PIX+x
- pix_data  out  16  pixel {first byte, second byte}
- frame_done  out  1  one-cycle pulse after last pixel of a frame is written
- busy  out  1  high in WAIT_SOF and RUN
- sync_err  out  1  sticky error flag

## Operation
- States: IDLE, WAIT_SOF, RUN, DONE. Reset -> IDLE.
- IDLE: capture=1 -> WAIT_SOF. Otherwise drain FIFO (fifo_rd = ~fifo_empty), data discarded.
- WAIT_SOF: drain and discard; sof=1 -> RUN with x=0, y=0, byte phase=0, sync_err cleared.
- RUN: fifo_rd = ~fifo_empty & ~last_byte_read (no read issued once the 2*H_PIX*V_LINES-th byte has been requested). Each returned word: if bit[1]=0 the word is dropped, sync_err set, phase unchanged. Else phase 0: latch byte as hi; phase 1: emit pixel {hi, byte}, advance x; x wraps H_PIX-1 -> 0 with y+1.
- Address kept as a running counter (incremented per pixel), not a multiplier; pix_addr = that counter.
- Last pixel (x=H_PIX-1, y=V_LINES-1) written -> DONE; frame_done pulses next cycle.
- DONE: one cycle; capture=1 -> WAIT_SOF (continuous mode), capture=0 -> IDLE.
- capture=0 in WAIT_SOF or RUN -> IDLE next cycle; partial pixel discarded, no frame_done, in-flight FIFO word discarded.
- sof in RUN (short frame): sync_err set, counters and phase zeroed, stay RUN; pixel completing in the same cycle is still written at its old address.
- sync_err sticky until next accepted sof from WAIT_SOF or reset.

## Timing
- Reset values: fifo_rd=0, pix_we=0, pix_addr=0, pix_data=0, frame_done=0, busy=0, sync_err=0; state IDLE, counters zero.
- fifo_rd in cycle N -> fifo_data sampled N+1 -> pix_we, pix_addr, pix_data registered, valid N+2 for second byte of pair.
- Full-rate throughput: one byte per clk, one pixel every 2 clk when FIFO non-empty.
- pix_addr/pix_data valid only while pix_we=1; held otherwise.
- fifo_rd never asserted when fifo_empty=1.
- frame_done occurs exactly 1 cycle after the final pix_we.
- rst=0 mid-frame: all outputs take reset values on the next edge, no write issued.

## Test plan
- Reset then capture=1, sof, feed 2*160*120 words {byte,1,0} with bytes 0x00,0x01,... -> 19200 pix_we, pix_addr 0..19199, first pix_data 0x0001, frame_done exactly once one cycle after last write, sync_err=0.
- Word with Href bit=0 injected at byte 5 -> word dropped, pixel pairing unshifted, sync_err=1 until next sof.
- capture drops after 1000 pixels -> IDLE next cycle, no further pix_we, no frame_done, FIFO drained to empty.
- Second sof after 50 pixels -> sync_err=1, next pixel at pix_addr 0.
- FIFO empty toggled every other cycle -> fifo_rd never high while empty, output stream identical to full-rate case.
- Continuous mode: capture held high, two frames with sof -> two frame_done pulses, addresses restart at 0.
